// File: rtl/dac_write_arbiter.sv
// Round-robin arbiter that lets several requesters share one DAC8411 frame writer.
// A grant captures the winner's code, strobes the writer, waits for its busy window
// (or a timeout), reports completion and then enforces an idle gap before the next grant.
module dac_write_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned DAC_WIDTH      = 16,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned IdxW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           areset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DAC_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic [NUM_REQ-1:0]             done,
    output logic [DAC_WIDTH-1:0]           dac_data,
    output logic                           dac_start,
    input  logic                           dac_busy,
    output logic [IdxW-1:0]                grant_idx,
    output logic                           timeout_err,
    input  logic                           err_clr,
    output logic [15:0]                    write_count
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StWaitDone,
        StGap
    } state_e;

    state_e                 state_q, state_d;
    state_e                 after_frame;
    logic                   armed_q;
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic [GapW-1:0]        gap_q, gap_d;
    logic [IdxW-1:0]        grant_q, grant_d;
    logic [DAC_WIDTH-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic                   err_q, err_d;
    logic [15:0]            write_count_q, write_count_d;

    logic                   found;
    logic [IdxW-1:0]        winner;
    logic [IdxW-1:0]        cand;
    int unsigned            rr_idx;
    logic [DAC_WIDTH-1:0]   win_data;

    // With no gap configured a finished frame drops straight back to idle.
    assign after_frame = (GAP_CYCLES == 0) ? StIdle : StGap;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found  = 1'b0;
        winner = grant_q;
        rr_idx = 0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (32'(grant_q) + k) % NUM_REQ;
            cand   = IdxW'(rr_idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Select the winner's code slice.
    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (IdxW'(k) == winner) begin
                win_data = req_data[k*DAC_WIDTH +: DAC_WIDTH];
            end
        end
    end

    // Next-state logic for the frame sequencer and its counters.
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        gap_d         = gap_q;
        grant_d       = grant_q;
        data_d        = data_q;
        done_d        = '0;
        err_d         = err_q;
        write_count_d = write_count_q;

        // Clear first so a timeout on the same edge overrides it.
        if (err_clr) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // armed_q holds off the first grant for one edge after reset release.
                if (armed_q && found) begin
                    grant_d = winner;
                    data_d  = win_data;
                    tmo_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                tmo_d   = tmo_q + 1'b1;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (dac_busy) begin
                    state_d = StWaitDone;
                end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    err_d           = 1'b1;
                    done_d[grant_q] = 1'b1;
                    gap_d           = '0;
                    state_d         = after_frame;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!dac_busy) begin
                    done_d[grant_q] = 1'b1;
                    write_count_d   = write_count_q + 16'd1;
                    gap_d           = '0;
                    state_d         = after_frame;
                end
            end
            StGap: begin
                if (gap_q == GapW'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset forces everything idle immediately.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q       <= StIdle;
            armed_q       <= 1'b0;
            tmo_q         <= '0;
            gap_q         <= '0;
            grant_q       <= IdxW'(NUM_REQ - 1);
            data_q        <= '0;
            done_q        <= '0;
            err_q         <= 1'b0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            armed_q       <= 1'b1;
            tmo_q         <= tmo_d;
            gap_q         <= gap_d;
            grant_q       <= grant_d;
            data_q        <= data_d;
            done_q        <= done_d;
            err_q         <= err_d;
            write_count_q <= write_count_d;
        end
    end

    // The ack pulse and the start strobe both mark the single START cycle.
    always_comb begin
        ack = '0;
        if (state_q == StStart) begin
            ack[grant_q] = 1'b1;
        end
    end

    assign dac_start   = (state_q == StStart);
    assign done        = done_q;
    assign dac_data    = data_q;
    assign grant_idx   = grant_q;
    assign timeout_err = err_q;
    assign write_count = write_count_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Randomized bench for dac_write_arbiter: requesters and a DAC writer are modelled at
// transaction level, and every cycle the outputs are compared against expectations
// derived from the frame timing rules.
module tb_dac_write_arbiter;

    localparam int NR        = 2;
    localparam int W         = 16;
    localparam int G         = 4;
    localparam int T         = 64;
    localparam int CycBudget = 20000;

    logic              clk = 1'b0;
    logic              areset;
    logic [NR-1:0]     req;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     ack;
    logic [NR-1:0]     done;
    logic [W-1:0]      dac_data;
    logic              dac_start;
    logic              dac_busy;
    logic [0:0]        grant_idx;
    logic              timeout_err;
    logic              err_clr;
    logic [15:0]       write_count;

    int cyc_cnt = 0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Posedge counter; cycle c is the interval after the c-th rising edge.
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    dac_write_arbiter #(
        .NUM_REQ        (NR),
        .DAC_WIDTH      (W),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .done        (done),
        .dac_data    (dac_data),
        .dac_start   (dac_start),
        .dac_busy    (dac_busy),
        .grant_idx   (grant_idx),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .write_count (write_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    // Round-robin pick: first requesting index after the last grant, wrapping around.
    function automatic int rr_pick(input int last, input logic [NR-1:0] r);
        logic [NR-1:0] sh;
        for (int k = 1; k <= NR; k++) begin
            sh = r >> ((last + k) % NR);
            if (sh[0]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_dac_start"}, dac_start, 0);
        check_eq({tag, "_ack"}, ack, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_timeout_err"}, timeout_err, 0);
        check_eq({tag, "_dac_data"}, dac_data, 0);
        check_eq({tag, "_write_count"}, write_count, 0);
        check_eq({tag, "_grant_idx"}, grant_idx, NR - 1);
    endtask

    initial begin
        int            c, win, start_c, done_c, d, len, free_c, hold_c, last_grant;
        int            nframes, nresets, k;
        bit            active, tmo, wrapped, to_now;
        logic [NR-1:0] req_s, exp_ack, exp_done, r;
        logic [NR*W-1:0] data_s;
        logic          clr_s, exp_start, exp_err;
        logic [15:0]   exp_data, exp_count;

        areset   = 1'b1;
        req      = '0;
        req_data = '0;
        dac_busy = 1'b0;
        err_clr  = 1'b0;
        active = 0; tmo = 0; wrapped = 0;
        win = 0; start_c = 0; done_c = 0; d = 0; len = 0; hold_c = 0;
        nframes = 0; nresets = 0;
        last_grant = NR - 1;
        exp_err = 1'b0; exp_data = '0; exp_count = '0;

        #1;
        check_reset_values("por");

        repeat (3) @(negedge clk);
        areset = 1'b0;
        req    = 2'b01;
        req_data[0 +: W] = 16'h1234;
        req_data[W +: W] = 16'hBEEF;
        free_c = cyc_cnt + 2;

        while (!(nframes >= 60 && !active)) begin
            @(negedge clk);
            c = cyc_cnt;
            if (c > CycBudget) begin
                check_eq("cycle_budget", c, CycBudget);
                break;
            end

            // Inputs as they were sampled at edge c.
            req_s  = req;
            data_s = req_data;
            clr_s  = err_clr;

            exp_start = 1'b0;
            exp_ack   = '0;
            exp_done  = '0;
            to_now    = 1'b0;

            if (!active && c >= free_c && req_s != 0) begin
                win        = rr_pick(last_grant, req_s);
                last_grant = win;
                exp_start  = 1'b1;
                exp_ack    = NR'(1) << win;
                exp_data   = W'(data_s >> (win * W));
                active     = 1;
                start_c    = c;
                if (nframes == 0) begin
                    tmo = 0; d = 0; len = 18;
                end else if (nframes <= 8) begin
                    tmo = 0; d = int'($urandom % 4); len = 1 + int'($urandom % 6);
                end else begin
                    tmo = ($urandom % 5 == 0); d = int'($urandom % 4);
                    len = 1 + int'($urandom % 20);
                end
                done_c  = tmo ? c + T : c + 2 + d + len;
                nframes++;
            end else if (active && c == done_c) begin
                exp_done = NR'(1) << win;
                active   = 0;
                free_c   = c + G + 1;
                if (tmo) to_now = 1'b1;
                else exp_count = exp_count + 16'd1;
            end

            if (to_now) exp_err = 1'b1;
            else if (clr_s) exp_err = 1'b0;

            check_eq("dac_start", dac_start, exp_start);
            check_eq("ack", ack, exp_ack);
            check_eq("done", done, exp_done);
            check_eq("grant_idx", grant_idx, last_grant);
            check_eq("dac_data", dac_data, exp_data);
            check_eq("write_count", write_count, exp_count);
            check_eq("timeout_err", timeout_err, exp_err);

            // Asynchronous reset in the middle of a busy frame.
            if (active && !tmo && nresets < 3 && nframes >= 15 + 10 * nresets &&
                c == start_c + 2 + d) begin
                #2 areset = 1'b1;
                #1;
                check_reset_values("mid_rst");
                active = 0; exp_err = 1'b0; exp_count = '0; exp_data = '0;
                last_grant = NR - 1;
                dac_busy = 1'b0; err_clr = 1'b0; req = 2'b11;
                repeat (2) begin
                    @(negedge clk);
                    check_eq("rst_done", done, 0);
                    check_eq("rst_start", dac_start, 0);
                end
                areset = 1'b0;
                free_c = cyc_cnt + 2;
                hold_c = cyc_cnt + 3;
                nresets++;
                continue;
            end

            // Jump the frame counter next to its wrap point.
            if (!wrapped && nframes >= 45 && !active) begin
                force dut.write_count_q = 16'hFFFF;
                #1;
                release dut.write_count_q;
                exp_count = 16'hFFFF;
                wrapped = 1;
            end

            // Drive inputs for edge c+1.
            k = c + 1;
            if (active && !tmo) dac_busy = (k >= start_c + 2 + d) && (k <= start_c + 1 + d + len);
            else if (active) dac_busy = 1'b0;
            else dac_busy = ($urandom % 4 == 0);

            if (active && tmo && k == done_c) err_clr = ($urandom % 2 == 0);
            else err_clr = ($urandom % 8 == 0);

            if (nframes == 0) begin
                req = 2'b01;
            end else if (nframes <= 8) begin
                req = 2'b11;
            end else begin
                r = req;
                for (int i = 0; i < NR; i++) begin
                    if (exp_ack[i]) r[i] = ($urandom % 2 == 0);
                    else if (r[i]) r[i] = (c < hold_c) ? 1'b1 : ($urandom % 32 != 0);
                    else r[i] = ($urandom % 4 == 0);
                end
                req = r;
            end

            for (int i = 0; i < NR; i++) begin
                if (!(nframes == 0 && i == 0) && ($urandom % 3 == 0)) begin
                    req_data[i*W +: W] = W'($urandom);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
